// File: rtl/lut_mult_pkg.sv
// Purpose : shared types and default widths for the lut_mult_8bit /
//           lut_div_8bit pair.
// Contents: state_t  - divider FSM states {IDLE, RUN, DONE}
//           DW, CW   - product/quotient width and its counter width for
//                      the default 8-bit operand size
package lut_mult_pkg;

  localparam int BIT_WIDTH_DEF = 8;
  localparam int DW            = 2 * BIT_WIDTH_DEF;
  localparam int CW            = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lut_div_step.sv
// Purpose : one combinational restoring-division step.
// Ports   : p       in   BIT_WIDTH    restored partial remainder (< divisor)
//           q_msb   in   1            next dividend bit shifted into p
//           divisor in   BIT_WIDTH    constant divisor
//           p_next  out  BIT_WIDTH    partial remainder after this step
//           q_bit   out  1            quotient bit produced by this step
module lut_div_step #(
  parameter int BIT_WIDTH = 8
) (
  input  logic [BIT_WIDTH-1:0] p,
  input  logic                 q_msb,
  input  logic [BIT_WIDTH-1:0] divisor,
  output logic [BIT_WIDTH-1:0] p_next,
  output logic                 q_bit
);

  logic        [BIT_WIDTH:0] shifted;
  logic signed [BIT_WIDTH:0] trial;

  // p < divisor, so shifted < 2*divisor and the trial difference always
  // fits BIT_WIDTH+1 signed bits; its sign bit selects restore.
  assign shifted = {p, q_msb};
  assign trial   = $signed(shifted) - $signed({1'b0, divisor});
  assign q_bit   = ~trial[BIT_WIDTH];
  assign p_next  = q_bit ? trial[BIT_WIDTH-1:0] : shifted[BIT_WIDTH-1:0];

endmodule

// File: rtl/lut_div_8bit.sv
// Purpose : sequential restoring divider by the constant A_const; returns
//           quotient, remainder and an exact flag for a 2*BIT_WIDTH dividend.
// Ports   : clk        in   1            rising-edge clock
//           rst_n      in   1            asynchronous active-low reset
//           in_valid   in   1            C is valid
//           in_ready   out  1            divider can accept C
//           C          in   2*BIT_WIDTH  dividend
//           out_valid  out  1            result valid
//           out_ready  in   1            consumer accepts the result
//           X          out  2*BIT_WIDTH  floor(C / A_const)
//           R          out  BIT_WIDTH    C mod A_const
//           exact      out  1            R == 0
module lut_div_8bit
  import lut_mult_pkg::*;
#(
  parameter int          BIT_WIDTH = 8,
  parameter int unsigned A_const   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*BIT_WIDTH-1:0] C,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*BIT_WIDTH-1:0] X,
  output logic [BIT_WIDTH-1:0]   R,
  output logic                   exact
);

  localparam int                   QW      = 2 * BIT_WIDTH;
  localparam int                   KW      = $clog2(QW);
  localparam logic [BIT_WIDTH-1:0] DIVISOR = A_const[BIT_WIDTH-1:0];

  if (A_const == 0 || A_const > (1 << BIT_WIDTH) - 1) begin : g_bad_a_const
    $fatal(1, "lut_div_8bit: A_const must lie in 1..2^BIT_WIDTH-1");
  end

  state_t               state, state_nxt;
  logic [KW-1:0]        count;
  logic [QW-1:0]        q_sh;
  logic [BIT_WIDTH-1:0] p_rem;
  logic [BIT_WIDTH-1:0] p_next;
  logic                 q_bit;
  logic                 accept;
  logic                 last_step;

  assign accept    = in_valid & in_ready;
  assign last_step = (state == RUN) && (count == '0);

  lut_div_step #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_step (
    .p      (p_rem),
    .q_msb  (q_sh[QW-1]),
    .divisor(DIVISOR),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      X     <= '0;
      R     <= '0;
      exact <= 1'b0;
    end else begin
      if (accept) begin
        count <= KW'(QW - 1);
      end else if (state == RUN && count != '0) begin
        count <= count - 1'b1;
      end
      // Results are captured from the final step, so they only move on DONE entry.
      if (last_step) begin
        X     <= {q_sh[QW-2:0], q_bit};
        R     <= p_next;
        exact <= (p_next == '0);
      end
    end
  end

  // Working registers: always reloaded on accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_sh  <= C;
      p_rem <= '0;
    end else if (state == RUN) begin
      q_sh  <= {q_sh[QW-2:0], q_bit};
      p_rem <= p_next;
    end
  end

endmodule
